// File: rtl/cfm_write_sequencer.sv
// cfm_write_sequencer
//   Streams a packet-buffer burst into the configuration flash, one 32-bit
//   word at a time. For every word it reads the buffer through the word-reader
//   handshake, then issues an address phase and a write-data phase to the CFM
//   data controller. The command FSM starts one burst per WRDATA packet.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   start/len/base    command strobe, byte length, first CFM word address
//   busy/done/error   status: busy for the whole burst, done pulse, sticky error
//   start_rd_ram/start_rd_addr, done_rd_ram/rd_word   buffer word reader
//   start_addr/start_wrdata/wr_addr_data/wr_data_data/done_data   CFM controller
module cfm_write_sequencer #(
  parameter int NUMBER  = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  len,
  input  logic [31:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        start_rd_ram,
  output logic [7:0]  start_rd_addr,
  input  logic        done_rd_ram,
  input  logic [31:0] rd_word,
  output logic        start_addr,
  output logic        start_wrdata,
  output logic [31:0] wr_addr_data,
  output logic [31:0] wr_data_data,
  input  logic        done_data
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, CHECK, RD_REQ, RD_WAIT, AD_REQ, AD_WAIT, WR_REQ, WR_WAIT, NEXT, DONE, ERR
  } state_t;

  state_t        state;
  logic [7:0]    len_q;
  logic [31:0]   addr;
  logic [5:0]    words_left;
  logic [TW-1:0] tcnt;

  logic len_bad;
  logic expired;

  assign len_bad = (len_q == 8'd0) || (len_q[1:0] != 2'b00) || (int'(len_q) > NUMBER);
  // Last permitted wait cycle; a done seen in this same cycle still wins.
  assign expired = (tcnt == TW'(TIMEOUT - 1));

  // start_rd_addr doubles as the byte-offset counter: it is only advanced in
  // NEXT, so it stays stable for the whole outstanding read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      len_q         <= '0;
      addr          <= '0;
      words_left    <= '0;
      tcnt          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      start_rd_ram  <= 1'b0;
      start_rd_addr <= '0;
      start_addr    <= 1'b0;
      start_wrdata  <= 1'b0;
      wr_addr_data  <= '0;
      wr_data_data  <= '0;
    end else begin
      start_rd_ram <= 1'b0;
      start_addr   <= 1'b0;
      start_wrdata <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: if (start) begin
          len_q <= len;
          addr  <= base_addr;
          error <= 1'b0;
          busy  <= 1'b1;
          state <= CHECK;
        end
        CHECK: if (len_bad) begin
          error <= 1'b1;
          done  <= 1'b1;
          state <= ERR;
        end else begin
          words_left    <= len_q[7:2];
          start_rd_addr <= 8'd0;
          start_rd_ram  <= 1'b1;
          tcnt          <= '0;
          state         <= RD_REQ;
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: if (done_rd_ram) begin
          wr_data_data <= rd_word;
          wr_addr_data <= addr;
          start_addr   <= 1'b1;
          tcnt         <= '0;
          state        <= AD_REQ;
        end else if (expired) begin
          error <= 1'b1;
          done  <= 1'b1;
          state <= ERR;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        AD_REQ: state <= AD_WAIT;
        AD_WAIT: if (done_data) begin
          start_wrdata <= 1'b1;
          tcnt         <= '0;
          state        <= WR_REQ;
        end else if (expired) begin
          error <= 1'b1;
          done  <= 1'b1;
          state <= ERR;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        WR_REQ: state <= WR_WAIT;
        WR_WAIT: if (done_data) begin
          state <= NEXT;
        end else if (expired) begin
          error <= 1'b1;
          done  <= 1'b1;
          state <= ERR;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        NEXT: begin
          words_left <= words_left - 6'd1;
          addr       <= addr + 32'd1;
          if (words_left == 6'd1) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            start_rd_addr <= start_rd_addr + 8'd4;
            start_rd_ram  <= 1'b1;
            tcnt          <= '0;
            state         <= RD_REQ;
          end
        end
        DONE, ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfm_write_sequencer.sv
// Bench for cfm_write_sequencer. Each command is turned into a per-cycle
// timeline from the documented latencies (strobe, wait, next-strobe gaps,
// timeout budget); the responders replay that timeline and one compare
// process checks every output against it on every cycle.
module tb_cfm_write_sequencer;
  localparam int NUMBER = 16;
  localparam int TO     = 8;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [7:0]  len = '0;
  logic [31:0] base_addr = '0;
  logic        busy, done, error, start_rd_ram, start_addr, start_wrdata;
  logic [7:0]  start_rd_addr;
  logic        done_rd_ram = 1'b0, done_data = 1'b0;
  logic [31:0] rd_word = '0, wr_addr_data, wr_data_data;

  cfm_write_sequencer #(.NUMBER(NUMBER), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .base_addr(base_addr),
    .busy(busy), .done(done), .error(error),
    .start_rd_ram(start_rd_ram), .start_rd_addr(start_rd_addr),
    .done_rd_ram(done_rd_ram), .rd_word(rd_word),
    .start_addr(start_addr), .start_wrdata(start_wrdata),
    .wr_addr_data(wr_addr_data), .wr_data_data(wr_data_data), .done_data(done_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  bit          e_rd[int], e_ad[int], e_wr[int], e_done[int], e_busy[int];
  bit          e_errset[int], e_errclr[int];
  logic [7:0]  e_rda[int];
  logic [31:0] e_wa[int], e_wd[int];
  bit          d_rd[int], d_dd[int];
  logic [31:0] d_rdw[int];
  logic [31:0] bufw[64];
  int          dly_rd[64], dly_ad[64], dly_wr[64];
  bit          stray_en = 1'b0;
  bit          m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_tables();
    e_rd.delete(); e_ad.delete(); e_wr.delete(); e_done.delete(); e_busy.delete();
    e_errset.delete(); e_errclr.delete(); e_rda.delete(); e_wa.delete(); e_wd.delete();
    d_rd.delete(); d_dd.delete(); d_rdw.delete();
  endtask

  // One handshake phase: strobe at s, responder answers d cycles later, or
  // never if d exceeds the timeout budget (then ERR lands TO+1 after s).
  // kind 0 = buffer read (v = offset), 1 = address (v = addr), 2 = data.
  task automatic phase(input int kind, input int s, input int d, input logic [31:0] v,
                       output int nxt, output bit tmo);
    int last;
    tmo  = (d > TO);
    last = tmo ? s + TO : s + d;
    case (kind)
      0: begin e_rd[s] = 1'b1; if (stray_en && $urandom_range(0, 1) == 1) d_dd[s] = 1'b1; end
      1: begin e_ad[s] = 1'b1; if (stray_en && $urandom_range(0, 1) == 1) d_dd[s] = 1'b1; end
      default: begin
        e_wr[s] = 1'b1;
        if (stray_en && $urandom_range(0, 1) == 1) begin d_rd[s] = 1'b1; d_rdw[s] = $urandom; end
      end
    endcase
    for (int c = s; c <= last; c++)
      case (kind)
        0: e_rda[c] = v[7:0];
        1: e_wa[c] = v;
        default: e_wd[c] = v;
      endcase
    if (!tmo) begin
      if (kind == 0) begin d_rd[s + d] = 1'b1; d_rdw[s + d] = bufw[v[7:2]]; end
      else d_dd[s + d] = 1'b1;
    end
    nxt = last + 1;
  endtask

  // Full timeline for a command accepted at cycle S; returns the done cycle.
  task automatic sched(input int S, input logic [7:0] l, input logic [31:0] b, output int dc);
    int t;
    bit tmo, err;
    e_errclr[S] = 1'b1;
    tmo = 1'b0;
    if (l == 0 || l % 4 != 0 || l > NUMBER) begin
      dc  = S + 1;
      err = 1'b1;
    end else begin
      t = S + 1;
      for (int w = 0; w < l / 4; w++) begin
        phase(0, t, dly_rd[w], 32'(4 * w), t, tmo); if (tmo) break;
        phase(1, t, dly_ad[w], b + 32'(w), t, tmo); if (tmo) break;
        phase(2, t, dly_wr[w], bufw[w], t, tmo);    if (tmo) break;
        t = t + 1;  // NEXT
      end
      dc  = t;
      err = tmo;
    end
    for (int c = S; c <= dc; c++) e_busy[c] = 1'b1;
    e_done[dc] = 1'b1;
    if (err) e_errset[dc] = 1'b1;
  endtask

  task automatic set_dly(input int lo, input int hi);
    for (int i = 0; i < 64; i++) begin
      dly_rd[i] = $urandom_range(hi, lo);
      dly_ad[i] = $urandom_range(hi, lo);
      dly_wr[i] = $urandom_range(hi, lo);
    end
  endtask

  task automatic run_cmd(input logic [7:0] l, input logic [31:0] b, input bit poke,
                         output int S, output int dc);
    @(negedge clk);
    S = cyc + 1;
    start = 1'b1; len = l; base_addr = b;
    sched(S, l, b, dc);
    @(negedge clk);
    start = 1'b0; len = 8'($urandom); base_addr = $urandom;
    if (poke && dc > S + 6) begin
      while (cyc < S + 4) @(negedge clk);
      start = 1'b1; len = 8'd4; base_addr = $urandom;
      @(negedge clk);
      start = 1'b0;
    end
    while (cyc < dc + 1) @(negedge clk);
  endtask

  // Responders replay the timeline.
  initial forever begin
    @(negedge clk);
    done_rd_ram = d_rd.exists(cyc);
    rd_word     = d_rdw.exists(cyc) ? d_rdw[cyc] : $urandom;
    done_data   = d_dd.exists(cyc);
  end

  // Compare process.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      m_err = 1'b0;
      chk("rst_ctl", {busy, done, error, start_rd_ram, start_addr, start_wrdata}, 32'd0);
      chk("rst_rda", start_rd_addr, 32'd0);
      chk("rst_wa", wr_addr_data, 32'd0);
      chk("rst_wd", wr_data_data, 32'd0);
    end else begin
      if (e_errclr.exists(cyc)) m_err = 1'b0;
      if (e_errset.exists(cyc)) m_err = 1'b1;
      chk("start_rd_ram", start_rd_ram, e_rd.exists(cyc));
      chk("start_addr", start_addr, e_ad.exists(cyc));
      chk("start_wrdata", start_wrdata, e_wr.exists(cyc));
      chk("done", done, e_done.exists(cyc));
      chk("busy", busy, e_busy.exists(cyc));
      chk("error", error, m_err);
      if (e_rda.exists(cyc)) chk("start_rd_addr", start_rd_addr, e_rda[cyc]);
      if (e_wa.exists(cyc))  chk("wr_addr_data", wr_addr_data, e_wa[cyc]);
      if (e_wd.exists(cyc))  chk("wr_data_data", wr_data_data, e_wd[cyc]);
    end
  end

  initial begin
    int S, dc;
    logic [7:0] l;
    for (int i = 0; i < 64; i++) bufw[i] = $urandom;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Nominal, zero-wait responders.
    set_dly(1, 1);
    run_cmd(8'd16, 32'h0000_AC10, 1'b0, S, dc);
    chk("pin_nom_done", dc - S, 32'd29);
    chk("pin_nom_a0", e_wa[S + 3], 32'h0000_AC10);
    chk("pin_nom_a3", e_wa[S + 24], 32'h0000_AC13);

    // CFM stalls 5 cycles per phase.
    for (int i = 0; i < 64; i++) begin dly_ad[i] = 5; dly_wr[i] = 5; end
    run_cmd(8'd16, $urandom, 1'b0, S, dc);
    chk("pin_stall_done", dc - S, 32'd61);

    // Bad lengths.
    set_dly(1, 1);
    run_cmd(8'd6, $urandom, 1'b0, S, dc);
    chk("pin_bad_done", dc - S, 32'd1);
    run_cmd(8'd0, $urandom, 1'b0, S, dc);
    run_cmd(8'd20, $urandom, 1'b0, S, dc);

    // Timeout after the second data strobe.
    dly_wr[1] = 100;
    run_cmd(8'd16, $urandom, 1'b0, S, dc);
    chk("pin_tmo_done", dc - S, 32'd21);

    // Address wrap plus an ignored start mid-burst.
    set_dly(1, 1);
    run_cmd(8'd8, 32'hFFFF_FFFF, 1'b1, S, dc);
    chk("pin_wrap_a0", e_wa[S + 3], 32'hFFFF_FFFF);
    chk("pin_wrap_a1", e_wa[S + 10], 32'h0000_0000);

    // Reset during the second word's address wait.
    set_dly(1, 1);
    dly_ad[1] = 6;
    @(negedge clk);
    S = cyc + 1;
    start = 1'b1; len = 8'd16; base_addr = 32'h1234_0000;
    sched(S, 8'd16, 32'h1234_0000, dc);
    @(negedge clk);
    start = 1'b0;
    while (cyc < S + 12) @(negedge clk);
    chk("pre_rst_busy", busy, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_ctl", {busy, done, error, start_rd_ram, start_addr, start_wrdata}, 32'd0);
    chk("async_rst_wa", wr_addr_data, 32'd0);
    clear_tables();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_cmd(8'd4, $urandom, 1'b0, S, dc);
    chk("pin_restart_done", dc - S, 32'd8);

    // Randomized traffic with stray dones, timeout boundary delays and pokes.
    stray_en = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) l = 8'($urandom_range(0, 255));
      else l = 8'(4 * $urandom_range(1, NUMBER / 4));
      set_dly(1, 4);
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0: dly_rd[$urandom_range(0, 3)] = $urandom_range(9, 8);
          1: dly_ad[$urandom_range(0, 3)] = $urandom_range(9, 8);
          default: dly_wr[$urandom_range(0, 3)] = $urandom_range(9, 8);
        endcase
      end
      run_cmd(l, $urandom, 1'($urandom_range(0, 1)), S, dc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
